// File: rtl/vector_cache_pkg.sv
// Shared types for the vector cache read path: RDB entry states and the
// upstream response payload bundle.
package vector_cache_pkg;

  localparam int RDB_ENTRY_NUM  = 16;
  localparam int RDB_DATA_WIDTH = 1024;
  localparam int RDB_ID_WIDTH   = 8;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    WAIT_DATA = 2'd1,
    FULL      = 2'd2
  } rdb_state_e;

  typedef struct packed {
    logic [RDB_DATA_WIDTH-1:0] data;
    logic [RDB_ID_WIDTH-1:0]   id;
  } us_data_pld_t;

endpackage

// File: rtl/rdb_ordered_agent_if.sv
// Request / fill / upstream / release bundle of the ordered RDB agent.
// The slave modport is the agent itself; master is the surrounding logic.
interface rdb_ordered_agent_if #(
  parameter int ENTRY_ID_WIDTH = 4,
  parameter int DATA_WIDTH     = 1024,
  parameter int ID_WIDTH       = 8
);

  logic                      req_vld;
  logic [ID_WIDTH-1:0]       req_id;
  logic                      req_rdy;
  logic                      alloc_vld;
  logic [ENTRY_ID_WIDTH-1:0] alloc_idx;

  logic                      fill_vld;
  logic [ENTRY_ID_WIDTH-1:0] fill_idx;
  logic [DATA_WIDTH-1:0]     fill_data;

  logic                      us_vld;
  logic [DATA_WIDTH-1:0]     us_data;
  logic [ID_WIDTH-1:0]       us_id;
  logic                      us_rdy;

  logic                      done_vld;
  logic [ENTRY_ID_WIDTH-1:0] done_idx;
  logic [ENTRY_ID_WIDTH:0]   occupancy;
  logic                      fill_err;

  modport slave (
    input  req_vld, req_id, fill_vld, fill_idx, fill_data, us_rdy,
    output req_rdy, alloc_vld, alloc_idx, us_vld, us_data, us_id,
           done_vld, done_idx, occupancy, fill_err
  );

  modport master (
    output req_vld, req_id, fill_vld, fill_idx, fill_data, us_rdy,
    input  req_rdy, alloc_vld, alloc_idx, us_vld, us_data, us_id,
           done_vld, done_idx, occupancy, fill_err
  );

endinterface

// File: rtl/rdb_ordered_agent_entry_array.sv
// Flop-based RDB data storage: one write port (fill), one asynchronous read
// port (head). Kept separate so it can be swapped for a register-file macro.
module rdb_entry_array #(
  parameter int ENTRY_NUM      = 16,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int DATA_WIDTH     = 1024
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ENTRY_ID_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [ENTRY_ID_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  logic [DATA_WIDTH-1:0] entry_rd [ENTRY_NUM];

  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
      data_d = data_q;
      if (wr_en && (wr_idx == ENTRY_ID_WIDTH'(gi))) begin
        data_d = wr_data;
      end
    end

    always_ff @(posedge clk) begin
      data_q <= data_d;
    end

    assign entry_rd[gi] = data_q;
  end

  assign rd_data = entry_rd[rd_idx];

endmodule

// File: rtl/rdb_ordered_agent.sv
// Ordered read-data-buffer agent: allocates entries in order, accepts fills
// out of order, returns data upstream strictly in allocation order.
module rdb_ordered_agent
  import vector_cache_pkg::*;
#(
  parameter int ENTRY_NUM      = RDB_ENTRY_NUM,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int DATA_WIDTH     = RDB_DATA_WIDTH,
  parameter int ID_WIDTH       = RDB_ID_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  rdb_ordered_agent_if.slave bus
);

  localparam int PTR_W = ENTRY_ID_WIDTH + 1;

  // Same layout as us_data_pld_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } us_pld_t;

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  rdb_state_e                state_q [ENTRY_NUM];
  rdb_state_e                state_d [ENTRY_NUM];
  logic [ID_WIDTH-1:0]       id_q    [ENTRY_NUM];
  logic [ID_WIDTH-1:0]       id_d    [ENTRY_NUM];
  logic                      done_vld_q, done_vld_d;
  logic [ENTRY_ID_WIDTH-1:0] done_idx_q, done_idx_d;
  logic                      fill_err_q, fill_err_d;

  logic [ENTRY_ID_WIDTH-1:0] wr_idx;
  logic [ENTRY_ID_WIDTH-1:0] rd_idx;
  logic                      buf_full;
  logic                      alloc;
  logic                      fill_ok;
  logic                      head_vld;
  logic                      drain;
  logic [DATA_WIDTH-1:0]     head_data;
  us_pld_t                   head;

  assign wr_idx   = wr_ptr_q[ENTRY_ID_WIDTH-1:0];
  assign rd_idx   = rd_ptr_q[ENTRY_ID_WIDTH-1:0];
  assign buf_full = (wr_idx == rd_idx) && (wr_ptr_q[ENTRY_ID_WIDTH] != rd_ptr_q[ENTRY_ID_WIDTH]);
  assign alloc    = bus.req_vld && !buf_full;
  assign fill_ok  = bus.fill_vld && (state_q[bus.fill_idx] == WAIT_DATA);
  assign head_vld = (state_q[rd_idx] == FULL);
  assign drain    = head_vld && bus.us_rdy;

  // Alloc, fill and drain touch entries in FREE, WAIT_DATA and FULL
  // respectively, so their indices can never collide within one cycle.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_vld_d = drain;
    done_idx_d = drain ? rd_idx : done_idx_q;
    fill_err_d = fill_err_q | (bus.fill_vld && !fill_ok);
    if (alloc) begin
      state_d[wr_idx] = WAIT_DATA;
      id_d[wr_idx]    = bus.req_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fill_ok) begin
      state_d[bus.fill_idx] = FULL;
    end
    if (drain) begin
      state_d[rd_idx] = FREE;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_vld_q <= 1'b0;
      done_idx_q <= '0;
      fill_err_q <= 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state_q[i] <= FREE;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_vld_q <= done_vld_d;
      done_idx_q <= done_idx_d;
      fill_err_q <= fill_err_d;
      state_q    <= state_d;
    end
  end

  // Request IDs are payload only; entry state alone decides validity.
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

  rdb_entry_array #(
    .ENTRY_NUM      (ENTRY_NUM),
    .ENTRY_ID_WIDTH (ENTRY_ID_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_entry_array (
    .clk     (clk),
    .wr_en   (fill_ok),
    .wr_idx  (bus.fill_idx),
    .wr_data (bus.fill_data),
    .rd_idx  (rd_idx),
    .rd_data (head_data)
  );

  assign head.data = head_data;
  assign head.id   = id_q[rd_idx];

  assign bus.req_rdy   = !buf_full;
  assign bus.alloc_vld = alloc;
  assign bus.alloc_idx = wr_idx;
  assign bus.us_vld    = head_vld;
  assign bus.us_data   = head.data;
  assign bus.us_id     = head.id;
  assign bus.done_vld  = done_vld_q;
  assign bus.done_idx  = done_idx_q;
  assign bus.occupancy = wr_ptr_q - rd_ptr_q;
  assign bus.fill_err  = fill_err_q;

endmodule

// File: tb/tb_rdb_ordered_agent.sv
// Directed self-checking bench for rdb_ordered_agent (16 entries, 1024b, 8b ID).
module tb_rdb_ordered_agent;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rdb_ordered_agent_if #(.ENTRY_ID_WIDTH(4), .DATA_WIDTH(1024), .ID_WIDTH(8)) bus ();

  rdb_ordered_agent #(
    .ENTRY_NUM(16), .ENTRY_ID_WIDTH(4), .DATA_WIDTH(1024), .ID_WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [1023:0] pat(input logic [7:0] k);
    logic [1023:0] v;
    for (int w = 0; w < 32; w++) v[w*32 +: 32] = {k, 8'(w), ~k, 8'hC3};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_vld = 1'b0; bus.req_id = '0;
    bus.fill_vld = 1'b0; bus.fill_idx = '0; bus.fill_data = '0;
    bus.us_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy: got %0b expected 1", bus.req_rdy); end
    n_checks++; if (bus.us_vld !== 1'b0) begin n_fail++; $display("FAIL reset_us_vld: got %0b expected 0", bus.us_vld); end
    n_checks++; if (bus.alloc_vld !== 1'b0) begin n_fail++; $display("FAIL reset_alloc_vld: got %0b expected 0", bus.alloc_vld); end
    n_checks++; if (bus.occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
    n_checks++; if (bus.done_vld !== 1'b0) begin n_fail++; $display("FAIL reset_done_vld: got %0b expected 0", bus.done_vld); end
    n_checks++; if (bus.done_idx !== 4'd0) begin n_fail++; $display("FAIL reset_done_idx: got %0d expected 0", bus.done_idx); end
    n_checks++; if (bus.fill_err !== 1'b0) begin n_fail++; $display("FAIL reset_fill_err: got %0b expected 0", bus.fill_err); end
    $display("test_reset done");
  endtask

  task automatic test_alloc_full();
    for (int i = 0; i < 16; i++) begin
      bus.req_vld = 1'b1; bus.req_id = 8'(i);
      #1;
      n_checks++; if (bus.alloc_vld !== 1'b1) begin n_fail++; $display("FAIL alloc_vld[%0d]: got %0b expected 1", i, bus.alloc_vld); end
      n_checks++; if (bus.alloc_idx !== 4'(i)) begin n_fail++; $display("FAIL alloc_idx[%0d]: got %0d expected %0d", i, bus.alloc_idx, i); end
      $display("alloc id=%0d idx=%0d", i, bus.alloc_idx);
      tick();
    end
    bus.req_id = 8'hEE;
    #1;
    n_checks++; if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL full_req_rdy: got %0b expected 0", bus.req_rdy); end
    n_checks++; if (bus.alloc_vld !== 1'b0) begin n_fail++; $display("FAIL full_alloc_vld: got %0b expected 0", bus.alloc_vld); end
    n_checks++; if (bus.occupancy !== 5'd16) begin n_fail++; $display("FAIL full_occupancy: got %0d expected 16", bus.occupancy); end
    n_checks++; if (bus.us_vld !== 1'b0) begin n_fail++; $display("FAIL full_us_vld: got %0b expected 0", bus.us_vld); end
    bus.req_vld = 1'b0;
    tick();
  endtask

  task automatic test_ooo_fill();
    logic [3:0] order [4];
    order[0] = 4'd3; order[1] = 4'd1; order[2] = 4'd0; order[3] = 4'd2;
    bus.us_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.fill_vld = 1'b1; bus.fill_idx = order[k]; bus.fill_data = pat(8'(order[k]));
      #1;
      if (k < 3) begin
        n_checks++; if (bus.us_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_hold_us_vld[%0d]: got %0b expected 0", k, bus.us_vld); end
      end else begin
        n_checks++; if (bus.us_vld !== 1'b1) begin n_fail++; $display("FAIL ooo_head_us_vld: got %0b expected 1", bus.us_vld); end
        n_checks++; if (bus.us_id !== 8'd0) begin n_fail++; $display("FAIL ooo_us_id[0]: got %0d expected 0", bus.us_id); end
        n_checks++; if (bus.us_data !== pat(8'd0)) begin n_fail++; $display("FAIL ooo_us_data[0]: got %08h expected %08h", bus.us_data[31:0], pat(8'd0) & 32'hFFFFFFFF); end
      end
      $display("fill idx=%0d us_vld=%0b", order[k], bus.us_vld);
      tick();
    end
    bus.fill_vld = 1'b0;
    for (int j = 1; j < 4; j++) begin
      #1;
      n_checks++; if (bus.done_vld !== 1'b1 || bus.done_idx !== 4'(j-1)) begin n_fail++; $display("FAIL ooo_done[%0d]: got vld=%0b idx=%0d expected vld=1 idx=%0d", j-1, bus.done_vld, bus.done_idx, j-1); end
      n_checks++; if (bus.us_vld !== 1'b1 || bus.us_id !== 8'(j)) begin n_fail++; $display("FAIL ooo_us_id[%0d]: got vld=%0b id=%0d expected vld=1 id=%0d", j, bus.us_vld, bus.us_id, j); end
      n_checks++; if (bus.us_data !== pat(8'(j))) begin n_fail++; $display("FAIL ooo_us_data[%0d]: got %08h", j, bus.us_data[31:0]); end
      $display("drain id=%0d done_idx=%0d", bus.us_id, bus.done_idx);
      tick();
    end
    #1;
    n_checks++; if (bus.done_vld !== 1'b1 || bus.done_idx !== 4'd3) begin n_fail++; $display("FAIL ooo_done[3]: got vld=%0b idx=%0d expected vld=1 idx=3", bus.done_vld, bus.done_idx); end
    n_checks++; if (bus.us_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_tail_us_vld: got %0b expected 0", bus.us_vld); end
    n_checks++; if (bus.occupancy !== 5'd12) begin n_fail++; $display("FAIL ooo_occupancy: got %0d expected 12", bus.occupancy); end
    tick();
    n_checks++; if (bus.done_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_done_pulse: got %0b expected 0", bus.done_vld); end
    bus.us_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.fill_vld = 1'b1; bus.fill_idx = 4'd4; bus.fill_data = pat(8'd4);
    tick();
    bus.fill_vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (bus.us_vld !== 1'b1 || bus.us_id !== 8'd4) begin n_fail++; $display("FAIL bp_head[%0d]: got vld=%0b id=%0d expected vld=1 id=4", c, bus.us_vld, bus.us_id); end
      n_checks++; if (bus.us_data !== pat(8'd4)) begin n_fail++; $display("FAIL bp_data[%0d]: got %08h", c, bus.us_data[31:0]); end
      n_checks++; if (bus.done_vld !== 1'b0) begin n_fail++; $display("FAIL bp_done[%0d]: got %0b expected 0", c, bus.done_vld); end
      $display("stall cycle=%0d us_vld=%0b", c, bus.us_vld);
      tick();
    end
    bus.us_rdy = 1'b1;
    tick();
    bus.us_rdy = 1'b0;
    #1;
    n_checks++; if (bus.done_vld !== 1'b1 || bus.done_idx !== 4'd4) begin n_fail++; $display("FAIL bp_release: got vld=%0b idx=%0d expected vld=1 idx=4", bus.done_vld, bus.done_idx); end
    n_checks++; if (bus.occupancy !== 5'd11) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected 11", bus.occupancy); end
    tick();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.req_vld = 1'b1; bus.req_id = 8'(8'h40 + i);
      tick();
    end
    bus.req_vld = 1'b0;
    bus.fill_vld = 1'b1; bus.fill_idx = 4'd0; bus.fill_data = pat(8'h40);
    tick();
    bus.fill_vld = 1'b0;
    bus.us_rdy = 1'b1; bus.req_vld = 1'b1; bus.req_id = 8'h99;
    #1;
    n_checks++; if (bus.us_vld !== 1'b1) begin n_fail++; $display("FAIL wrap_us_vld: got %0b expected 1", bus.us_vld); end
    n_checks++; if (bus.req_rdy !== 1'b0 || bus.alloc_vld !== 1'b0) begin n_fail++; $display("FAIL wrap_no_bypass: got rdy=%0b alloc=%0b expected 0 0", bus.req_rdy, bus.alloc_vld); end
    $display("drain while full: id=%0h", bus.us_id);
    tick();
    bus.us_rdy = 1'b0;
    #1;
    n_checks++; if (bus.alloc_vld !== 1'b1 || bus.alloc_idx !== 4'd0) begin n_fail++; $display("FAIL wrap_alloc: got vld=%0b idx=%0d expected vld=1 idx=0", bus.alloc_vld, bus.alloc_idx); end
    n_checks++; if (bus.done_vld !== 1'b1 || bus.done_idx !== 4'd0) begin n_fail++; $display("FAIL wrap_done: got vld=%0b idx=%0d expected vld=1 idx=0", bus.done_vld, bus.done_idx); end
    n_checks++; if (bus.occupancy !== 5'd15) begin n_fail++; $display("FAIL wrap_occ_mid: got %0d expected 15", bus.occupancy); end
    tick();
    bus.req_vld = 1'b0;
    #1;
    n_checks++; if (bus.occupancy !== 5'd16 || bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL wrap_refull: got occ=%0d rdy=%0b expected occ=16 rdy=0", bus.occupancy, bus.req_rdy); end
    $display("wrap alloc idx=0 occupancy=%0d", bus.occupancy);
    tick();
  endtask

  task automatic test_fill_err();
    do_reset();
    bus.fill_vld = 1'b1; bus.fill_idx = 4'd7; bus.fill_data = pat(8'hBB);
    #1;
    n_checks++; if (bus.fill_err !== 1'b0) begin n_fail++; $display("FAIL ferr_before: got %0b expected 0", bus.fill_err); end
    tick();
    bus.fill_vld = 1'b0;
    #1;
    n_checks++; if (bus.fill_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %0b expected 1", bus.fill_err); end
    n_checks++; if (bus.us_vld !== 1'b0 || bus.occupancy !== 5'd0) begin n_fail++; $display("FAIL ferr_no_effect: got vld=%0b occ=%0d expected 0 0", bus.us_vld, bus.occupancy); end
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.req_vld = 1'b1; bus.req_id = 8'(8'h70 + i);
      tick();
    end
    bus.req_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.fill_vld = 1'b1; bus.fill_idx = 4'(i); bus.fill_data = pat(8'(8'h70 + i));
      tick();
    end
    bus.fill_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.us_rdy = 1'b1; bus.req_vld = 1'b1; bus.req_id = 8'(8'h80 + k);
      #1;
      n_checks++; if (bus.us_vld !== 1'b1 || bus.us_id !== 8'(8'h70 + k)) begin n_fail++; $display("FAIL ferr_drain_id[%0d]: got vld=%0b id=%0h expected vld=1 id=%0h", k, bus.us_vld, bus.us_id, 8'h70 + k); end
      n_checks++; if (bus.us_data !== pat(8'(8'h70 + k))) begin n_fail++; $display("FAIL ferr_drain_data[%0d]: got %08h", k, bus.us_data[31:0]); end
      n_checks++; if (bus.alloc_idx !== 4'(8 + k) || bus.occupancy !== 5'd8) begin n_fail++; $display("FAIL ferr_alloc_drain[%0d]: got idx=%0d occ=%0d expected idx=%0d occ=8", k, bus.alloc_idx, bus.occupancy, 8 + k); end
      $display("drain+alloc id=%0h alloc_idx=%0d", bus.us_id, bus.alloc_idx);
      tick();
    end
    bus.us_rdy = 1'b0; bus.req_vld = 1'b0;
    #1;
    n_checks++; if (bus.occupancy !== 5'd8 || bus.us_vld !== 1'b0) begin n_fail++; $display("FAIL ferr_after: got occ=%0d vld=%0b expected occ=8 vld=0", bus.occupancy, bus.us_vld); end
    n_checks++; if (bus.fill_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %0b expected 1", bus.fill_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 8; i < 12; i++) begin
      bus.fill_vld = 1'b1; bus.fill_idx = 4'(i); bus.fill_data = pat(8'(i));
      tick();
    end
    bus.fill_vld = 1'b0;
    #1;
    n_checks++; if (bus.us_vld !== 1'b1 || bus.us_id !== 8'h80) begin n_fail++; $display("FAIL rmid_pre: got vld=%0b id=%0h expected vld=1 id=80", bus.us_vld, bus.us_id); end
    rst_n = 1'b0; bus.us_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.occupancy !== 5'd0) begin n_fail++; $display("FAIL rmid_occupancy: got %0d expected 0", bus.occupancy); end
    n_checks++; if (bus.us_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_flags: got vld=%0b rdy=%0b expected 0 1", bus.us_vld, bus.req_rdy); end
    n_checks++; if (bus.done_vld !== 1'b0 || bus.fill_err !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got done=%0b err=%0b expected 0 0", bus.done_vld, bus.fill_err); end
    tick();
    n_checks++; if (bus.done_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: got %0b expected 0", bus.done_vld); end
    $display("reset mid-operation occupancy=%0d", bus.occupancy);
    bus.us_rdy = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alloc_full();
    test_ooo_fill();
    test_backpressure();
    test_full_wrap();
    test_fill_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
